// File: rtl/lsu_ctrl.sv
// Load/store unit: one request at a time over an IDLE/ACCESS/RESP FSM, decoding RAM, LED register and switch port.
// Optional build macro LSU_MISALIGN_TRAP_EN turns misaligned half/word accesses into errors instead of aligning them down.
module lsu_ctrl #(
   parameter int unsigned DMEM_WORDS = 512,
   parameter logic [31:0] LEDR_ADDR  = 32'h1000_0000,
   parameter logic [31:0] SW_ADDR    = 32'h1001_0000
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   // Handshake: a request transfers on a rising edge where i_req and o_ready are both high;
   // the requester holds i_req and its payload until then. The response is a single-cycle
   // o_rsp_valid strobe two cycles after the accepting cycle; there is no response backpressure.
   input  logic        i_req,
   output logic        o_ready,
   input  logic        i_we,
   input  logic [2:0]  i_funct3,
   input  logic [31:0] i_addr,
   input  logic [31:0] i_st_data,
   output logic        o_rsp_valid,
   output logic [31:0] o_ld_data,
   output logic        o_err,
   output logic [31:0] o_ledr,
   input  logic [31:0] i_sw,
   output logic [1:0]  o_state
);

   localparam int unsigned AW         = $clog2(DMEM_WORDS);
   localparam logic [31:0] DMEM_BYTES = 32'(DMEM_WORDS) << 2;

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t state, state_nxt;

   logic        we_q;
   logic [2:0]  f3_q;
   logic [31:0] addr_q;
   logic [31:0] st_q;

   logic [31:0] mem [DMEM_WORDS];

   logic        illegal, misalign, err;
   logic [31:0] eff_addr;
   logic        hit_ram, hit_led, hit_sw;
   logic [AW-1:0] ram_idx;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] src_word, shifted, ld_fmt, ld_result;
   logic        wr_en;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:   if (i_req) state_nxt = S_ACCESS;
         S_ACCESS: state_nxt = S_RESP;
         S_RESP:   state_nxt = S_IDLE;
         default:  state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      o_ready     = (state == S_IDLE);
      o_rsp_valid = (state == S_RESP);
      o_state     = state;
   end

   always_ff @(posedge i_clk) begin
      if (state == S_IDLE && i_req) begin
         we_q   <= i_we;
         f3_q   <= i_funct3;
         addr_q <= i_addr;
         st_q   <= i_st_data;
      end
   end

   always_comb begin
      illegal  = (f3_q[1:0] == 2'b11) || (f3_q[2] && f3_q[1]);
      misalign = ((f3_q[1:0] == 2'b01) && addr_q[0]) ||
                 ((f3_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
      eff_addr = addr_q;
`ifdef LSU_MISALIGN_TRAP_EN
      err = illegal || misalign;
`else
      err = illegal;
      // Misaligned half/word accesses silently drop the offending low bits.
      if (f3_q[1:0] == 2'b01) eff_addr[0]   = 1'b0;
      if (f3_q[1:0] == 2'b10) eff_addr[1:0] = 2'b00;
`endif
      hit_ram = (eff_addr < DMEM_BYTES);
      hit_led = !hit_ram && (eff_addr[31:2] == LEDR_ADDR[31:2]);
      hit_sw  = !hit_ram && !hit_led && (eff_addr[31:2] == SW_ADDR[31:2]);
      ram_idx = eff_addr[AW+1:2];

      case (f3_q[1:0])
         2'b00:   begin be = 4'b0001 << eff_addr[1:0];             wdata = {4{st_q[7:0]}};  end
         2'b01:   begin be = eff_addr[1] ? 4'b1100 : 4'b0011;      wdata = {2{st_q[15:0]}}; end
         default: begin be = 4'b1111;                              wdata = st_q;            end
      endcase

      if (hit_ram)      src_word = mem[ram_idx];
      else if (hit_led) src_word = o_ledr;
      else if (hit_sw)  src_word = i_sw;
      else              src_word = 32'h0;

      shifted = src_word >> {eff_addr[1:0], 3'b000};
      case (f3_q)
         3'b000:  ld_fmt = {{24{shifted[7]}}, shifted[7:0]};
         3'b100:  ld_fmt = {24'h0, shifted[7:0]};
         3'b001:  ld_fmt = {{16{shifted[15]}}, shifted[15:0]};
         3'b101:  ld_fmt = {16'h0, shifted[15:0]};
         default: ld_fmt = src_word;
      endcase

      ld_result = (we_q || err) ? 32'h0 : ld_fmt;
      wr_en     = (state == S_ACCESS) && we_q && !err;
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         o_ld_data <= 32'h0;
         o_err     <= 1'b0;
         o_ledr    <= 32'h0;
      end else begin
         if (state == S_ACCESS) begin
            o_ld_data <= ld_result;
            o_err     <= err;
         end
         if (wr_en && hit_led) begin
            for (int i = 0; i < 4; i++)
               if (be[i]) o_ledr[8*i +: 8] <= wdata[8*i +: 8];
         end
      end
   end

   // Data RAM has no reset; a write issued in ACCESS commits on that edge.
   always_ff @(posedge i_clk) begin
      if (wr_en && hit_ram) begin
         for (int i = 0; i < 4; i++)
            if (be[i]) mem[ram_idx][8*i +: 8] <= wdata[8*i +: 8];
      end
   end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized accesses against a byte-level reference model.
// Expectations follow LSU_MISALIGN_TRAP_EN when it is defined for the build.
module tb_lsu_ctrl;

   localparam int          DMEM_WORDS = 512;
   localparam int          DMEM_BYTES = DMEM_WORDS * 4;
   localparam logic [31:0] LEDR_ADDR  = 32'h1000_0000;
   localparam logic [31:0] SW_ADDR    = 32'h1001_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        i_req, i_we;
   logic [2:0]  i_funct3;
   logic [31:0] i_addr, i_st_data, i_sw;
   logic        o_ready, o_rsp_valid, o_err;
   logic [31:0] o_ld_data, o_ledr;
   logic [1:0]  o_state;

   lsu_ctrl #(.DMEM_WORDS(DMEM_WORDS), .LEDR_ADDR(LEDR_ADDR), .SW_ADDR(SW_ADDR)) dut (
      .i_clk(clk), .i_rst_n(rst_n), .i_req(i_req), .o_ready(o_ready),
      .i_we(i_we), .i_funct3(i_funct3), .i_addr(i_addr), .i_st_data(i_st_data),
      .o_rsp_valid(o_rsp_valid), .o_ld_data(o_ld_data), .o_err(o_err),
      .o_ledr(o_ledr), .i_sw(i_sw), .o_state(o_state)
   );

   always #5 clk = ~clk;

   int n_vec  = 0;
   int n_miss = 0;
   logic [31:0] exp_q[$];
   logic [7:0]  ram_m [DMEM_BYTES];
   logic [31:0] led_m = 32'h0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      if (obs !== exp) begin
         n_miss++;
         $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
      end
   endtask

   // Reference model: memory as bytes, each access a run of 1/2/4 little-endian bytes.
   task automatic model_access(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                               input logic [31:0] sd, output logic [31:0] exp_d, output logic exp_e);
      int          nb, region, k;
      logic [31:0] a, v;
      logic [7:0]  b8;
      exp_d = 32'h0;
      exp_e = 1'b0;
      if (!(f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101})) begin
         exp_e = 1'b1;
         return;
      end
      nb = 1 << f3[1:0];
      a  = addr;
`ifdef LSU_MISALIGN_TRAP_EN
      if ((addr % nb) != 0) begin
         exp_e = 1'b1;
         return;
      end
`else
      a = addr - (addr % nb);
`endif
      if (a < DMEM_BYTES)                region = 0;
      else if (a / 4 == LEDR_ADDR / 4)   region = 1;
      else if (a / 4 == SW_ADDR / 4)     region = 2;
      else                               region = 3;
      v = 32'h0;
      for (int b = 0; b < nb; b++) begin
         k = int'(a % 4) + b;
         if (we) begin
            b8 = sd[8*b +: 8];
            if (region == 0)      ram_m[int'(a) + b] = b8;
            else if (region == 1) led_m[8*k +: 8] = b8;
         end else begin
            if (region == 0)      b8 = ram_m[int'(a) + b];
            else if (region == 1) b8 = led_m[8*k +: 8];
            else if (region == 2) b8 = i_sw[8*k +: 8];
            else                  b8 = 8'h0;
            v[8*b +: 8] = b8;
         end
      end
      if (!we && nb < 4 && !f3[2] && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
      if (!we) exp_d = v;
   endtask

   task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] sd, output logic [31:0] got);
      logic [31:0] ed;
      logic        ee;
      int          guard;
      got = 32'h0;
      @(negedge clk);
      i_req = 1'b1; i_we = we; i_funct3 = f3; i_addr = addr; i_st_data = sd;
      guard = 0;
      while (o_ready !== 1'b1 && guard < 4) begin
         @(negedge clk);
         guard++;
      end
      if (o_ready !== 1'b1) begin
         check("accept_timeout", {31'b0, o_ready}, 32'd1);
         i_req = 1'b0;
         return;
      end
      model_access(we, f3, addr, sd, ed, ee);
      exp_q.push_back(ed);
      @(posedge clk);
      @(negedge clk);
      i_req = 1'b0; i_we = 1'($urandom); i_funct3 = 3'($urandom);
      i_addr = $urandom; i_st_data = $urandom;
      check("access_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
      check("access_ready", {31'b0, o_ready}, 32'd0);
      @(negedge clk);
      check("resp_valid", {31'b0, o_rsp_valid}, 32'd1);
      check("resp_ready", {31'b0, o_ready}, 32'd0);
      got = o_ld_data;
      check("ld_data", o_ld_data, exp_q.pop_front());
      check("err", {31'b0, o_err}, {31'b0, ee});
      check("ledr", o_ledr, led_m);
   endtask

   logic [31:0] got;
   logic [31:0] ra;
   int          last_acc, n_acc, n_rsp;

   initial begin
      rst_n = 1'b0; i_req = 1'b0; i_we = 1'b0; i_funct3 = 3'b010;
      i_addr = 32'h0; i_st_data = 32'h0; i_sw = 32'h0;
      repeat (3) @(negedge clk);
      check("rst_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
      check("rst_ld_data", o_ld_data, 32'd0);
      check("rst_err", {31'b0, o_err}, 32'd0);
      check("rst_ledr", o_ledr, 32'd0);
      check("rst_ready", {31'b0, o_ready}, 32'd1);
      check("rst_state", {30'b0, o_state}, 32'd0);
      rst_n = 1'b1;

      // Give the low RAM region and the top word defined contents.
      for (int w = 0; w < 64; w++) issue(1'b1, 3'b010, 32'(w * 4), $urandom, got);
      issue(1'b1, 3'b010, 32'(DMEM_BYTES - 4), 32'h1357_9BDF, got);

      issue(1'b1, 3'b010, 32'h10, 32'hDEAD_BEEF, got);
      check("sw_ld_data_zero", got, 32'h0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, got);
      check("lw_deadbeef", got, 32'hDEAD_BEEF);

      issue(1'b1, 3'b000, 32'h11, 32'h0000_0080, got);
      issue(1'b0, 3'b010, 32'h10, 32'h0, got);
      check("lw_after_sb", got, 32'hDEAD_80EF);
      issue(1'b0, 3'b000, 32'h11, 32'h0, got);
      check("lb_signed", got, 32'hFFFF_FF80);
      issue(1'b0, 3'b100, 32'h11, 32'h0, got);
      check("lbu_zero", got, 32'h0000_0080);
      issue(1'b0, 3'b101, 32'h12, 32'h0, got);
      check("lhu_upper", got, 32'h0000_DEAD);

      issue(1'b1, 3'b010, LEDR_ADDR, 32'h0000_00A5, got);
      check("ledr_a5", o_ledr, 32'h0000_00A5);
      i_sw = 32'h0000_1234;
      issue(1'b0, 3'b010, SW_ADDR, 32'h0, got);
      check("sw_read", got, 32'h0000_1234);

      issue(1'b0, 3'b010, 32'h12, 32'h0, got);
`ifdef LSU_MISALIGN_TRAP_EN
      check("lw_misaligned_data", got, 32'h0);
      check("lw_misaligned_err", {31'b0, o_err}, 32'd1);
`else
      check("lw_misaligned_data", got, 32'hDEAD_80EF);
      check("lw_misaligned_err", {31'b0, o_err}, 32'd0);
`endif

      issue(1'b1, 3'b011, 32'h10, 32'h1111_1111, got);
      check("illegal_err", {31'b0, o_err}, 32'd1);
      issue(1'b0, 3'b010, 32'h10, 32'h0, got);
      check("illegal_no_write", got, 32'hDEAD_80EF);

      issue(1'b0, 3'b010, 32'(DMEM_BYTES - 4), 32'h0, got);
      check("last_ram_word", got, 32'h1357_9BDF);
      issue(1'b1, 3'b010, 32'(DMEM_BYTES), 32'hFFFF_FFFF, got);
      issue(1'b0, 3'b010, 32'(DMEM_BYTES), 32'h0, got);
      check("unmapped_zero", got, 32'h0);

      for (int n = 0; n < 250; n++) begin
         case ($urandom_range(0, 9))
            0:       ra = LEDR_ADDR + 32'($urandom_range(0, 3));
            1:       ra = SW_ADDR + 32'($urandom_range(0, 3));
            2:       ra = ($urandom_range(0, 1) == 0 ? 32'(DMEM_BYTES) : 32'h2000_0000)
                          + 32'($urandom_range(0, 255));
            default: ra = 32'($urandom_range(0, 255));
         endcase
         if ($urandom_range(0, 7) == 0) i_sw = $urandom;
         issue(1'($urandom), 3'($urandom), ra, $urandom, got);
      end

      // Back-to-back requests with i_req held high.
      i_sw = 32'hCAFE_0001;
      last_acc = 0; n_acc = 0; n_rsp = 0;
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = SW_ADDR;
      for (int c = 0; c < 15; c++) begin
         if (c > 0) @(negedge clk);
         if (o_rsp_valid) begin
            n_rsp++;
            check("stream_data", o_ld_data, 32'hCAFE_0001);
         end
         if (o_ready) begin
            if (n_acc > 0) check("stream_gap", 32'(c - last_acc), 32'd3);
            last_acc = c;
            n_acc++;
         end
      end
      i_req = 1'b0;
      @(negedge clk);
      if (o_rsp_valid) n_rsp++;
      check("stream_accepts", 32'(n_acc), 32'd5);
      check("stream_rsps", 32'(n_rsp), 32'd5);

      // Reset while a load is in ACCESS aborts it.
      issue(1'b1, 3'b010, LEDR_ADDR, 32'h0000_005A, got);
      @(negedge clk);
      i_req = 1'b1; i_we = 1'b0; i_funct3 = 3'b010; i_addr = 32'h10;
      @(posedge clk);
      @(negedge clk);
      i_req = 1'b0;
      check("abort_in_access", {31'b0, o_ready}, 32'd0);
      rst_n = 1'b0;
      @(negedge clk);
      led_m = 32'h0;
      check("abort_rsp_valid", {31'b0, o_rsp_valid}, 32'd0);
      check("abort_ledr", o_ledr, 32'h0);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", {31'b0, o_ready}, 32'd1);
      check("post_rst_no_rsp", {31'b0, o_rsp_valid}, 32'd0);
      issue(1'b0, 3'b010, 32'h10, 32'h0, got);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
